// File: rtl/mem_adapter_pkg.sv
// Shared types and default sizes for the dual-port memory adapter.
package mem_adapter_pkg;

  localparam int ADDR_WIDTH_DEF = 7;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACK     = 2'd1,
    ST_RECOVER = 2'd2
  } port_state_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// Per-port handshake: accept request in IDLE, ack one cycle later, then one dead cycle.
// Latency 1 edge to dready; requests are ignored outside IDLE.
import mem_adapter_pkg::*;

module mem_port_ctrl #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  access_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dready_o
);

  port_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    dout_d   = dout_q;
    access_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i && !rst) begin
          // rdata_i is the pre-write word, which gives read-first behaviour
          access_o = 1'b1;
          dout_d   = rdata_i;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:     state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign dout_o   = dout_q;
  assign dready_o = (state_q == ST_ACK);

endmodule

// File: rtl/dual_port_mem_adapter.sv
// Dual-port word RAM with per-port req/ready handshake and byte write enables.
// Ready one edge after request; a held request repeats every 3 cycles.
import mem_adapter_pkg::*;

module dual_port_mem_adapter #(
  parameter int    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter string INIT_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rea,
  input  logic [BYTES_PER_WORD-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]     addra,
  input  logic [DATA_WIDTH-1:0]     dina,
  output logic [DATA_WIDTH-1:0]     douta,
  output logic                      dreadya,
  input  logic                      reb,
  input  logic [BYTES_PER_WORD-1:0] web,
  input  logic [ADDR_WIDTH-1:0]     addrb,
  input  logic [DATA_WIDTH-1:0]     dinb,
  output logic [DATA_WIDTH-1:0]     doutb,
  output logic                      dreadyb
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  acc_a, acc_b;

  initial begin
    for (int k = 0; k < DEPTH; k++) mem_q[k] = '0;
  end

  mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .req_i    (rea | (|wea)),
    .rdata_i  (mem_q[addra]),
    .access_o (acc_a),
    .dout_o   (douta),
    .dready_o (dreadya)
  );

  mem_port_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .req_i    (reb | (|web)),
    .rdata_i  (mem_q[addrb]),
    .access_o (acc_b),
    .dout_o   (doutb),
    .dready_o (dreadyb)
  );

  // Port B's assignments come last so it wins per byte on a same-address collision.
  always @(posedge clk) begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (acc_a && wea[i]) mem_q[addra][8*i +: 8] <= dina[8*i +: 8];
    end
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (acc_b && web[i]) mem_q[addrb][8*i +: 8] <= dinb[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_dual_port_mem_adapter.sv
// Directed bench for dual_port_mem_adapter: handshake timing, byte enables, collisions, reset.
module tb_dual_port_mem_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rea, reb;
  logic [3:0]  wea, web;
  logic [6:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;
  logic        dreadya, dreadyb;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dual_port_mem_adapter #(.ADDR_WIDTH(7), .DATA_WIDTH(32), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst),
    .rea(rea), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .dreadya(dreadya),
    .reb(reb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .dreadyb(dreadyb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive both ports at a negedge, then land on the negedge where dready should be high.
  task automatic acc(input logic ra, input logic [3:0] wa, input logic [6:0] aa, input logic [31:0] da,
                     input logic rb, input logic [3:0] wb, input logic [6:0] ab, input logic [31:0] db);
    rea = ra; wea = wa; addra = aa; dina = da;
    reb = rb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drop requests and let the FSMs pass through RECOVER back to IDLE.
  task automatic rel();
    rea = 1'b0; wea = '0; addra = '0; dina = '0;
    reb = 1'b0; web = '0; addrb = '0; dinb = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] pat;
    pat = 9'b010010010;
    rst = 1'b1;
    rea = 1'b0; wea = '0; addra = '0; dina = '0;
    reb = 1'b0; web = '0; addrb = '0; dinb = '0;

    #1;
    check("rst_douta", douta, 32'h0);
    check("rst_doutb", doutb, 32'h0);
    check("rst_dreadya", {31'h0, dreadya}, 32'h0);
    check("rst_dreadyb", {31'h0, dreadyb}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // pure write on B returns the old (zero) word
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b0, 4'hF, 7'd5, 32'hDEADBEEF);
    check("wr5_dreadyb", {31'h0, dreadyb}, 32'h1);
    check("wr5_dreadya_idle", {31'h0, dreadya}, 32'h0);
    check("wr5_old_word", doutb, 32'h0);
    rea = 1'b0; wea = '0; reb = 1'b0; web = '0;
    @(negedge clk);
    check("wr5_dreadyb_one_cycle", {31'h0, dreadyb}, 32'h0);
    @(negedge clk);

    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b1, 4'h0, 7'd5, 32'h0);
    check("rd5_dreadyb", {31'h0, dreadyb}, 32'h1);
    check("rd5_doutb", doutb, 32'hDEADBEEF);
    rel();

    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b0, 4'b0010, 7'd5, 32'h0000_5500);
    check("be_write_old", doutb, 32'hDEADBEEF);
    rel();
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b1, 4'h0, 7'd5, 32'h0);
    check("be_read", doutb, 32'hDEAD55EF);
    check("doutb_hold_next", doutb, 32'hDEAD55EF);
    rel();
    check("doutb_hold_idle", doutb, 32'hDEAD55EF);

    // read-first across ports
    acc(1'b0, 4'hF, 7'd9, 32'h11111111, 1'b0, 4'h0, 7'd0, 32'h0);
    rel();
    acc(1'b1, 4'h0, 7'd9, 32'h0, 1'b0, 4'hF, 7'd9, 32'h22222222);
    check("rf_douta_old", douta, 32'h11111111);
    check("rf_doutb_old", doutb, 32'h11111111);
    check("rf_both_ready", {30'h0, dreadya, dreadyb}, 32'h3);
    rel();
    acc(1'b1, 4'h0, 7'd9, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    check("rf_read9_new", douta, 32'h22222222);
    rel();

    // write-write collisions
    acc(1'b0, 4'hF, 7'd3, 32'hAAAAAAAA, 1'b0, 4'hF, 7'd3, 32'hBBBBBBBB);
    rel();
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b1, 4'h0, 7'd3, 32'h0);
    check("ww_full_b_wins", doutb, 32'hBBBBBBBB);
    rel();
    acc(1'b0, 4'hF, 7'd3, 32'hAAAAAAAA, 1'b0, 4'b0011, 7'd3, 32'hCCCCCCCC);
    rel();
    acc(1'b1, 4'h0, 7'd3, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    check("ww_partial_merge", douta, 32'hAAAACCCC);
    rel();

    // last word and held-request cadence
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b0, 4'hF, 7'd127, 32'h12345678);
    rel();
    rea = 1'b1; addra = 7'd127;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("held_dreadya_%0d", i), {31'h0, dreadya}, {31'h0, pat[8-i]});
      if (i == 1) check("held_douta_127", douta, 32'h12345678);
      @(negedge clk);
    end
    rel();

    // reset in the middle of an ack
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b1, 4'h0, 7'd5, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_dreadyb", {31'h0, dreadyb}, 32'h0);
    check("midrst_doutb", doutb, 32'h0);
    check("midrst_douta", douta, 32'h0);
    rea = 1'b0; wea = '0; reb = 1'b0; web = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    acc(1'b0, 4'h0, 7'd0, 32'h0, 1'b1, 4'h0, 7'd5, 32'h0);
    check("post_rst_word5", doutb, 32'hDEAD55EF);
    rel();
    acc(1'b1, 4'h0, 7'd9, 32'h0, 1'b0, 4'h0, 7'd0, 32'h0);
    check("post_rst_word9", douta, 32'h22222222);
    rel();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
